rca_8bit: RTL and testbench



---
 rtl/rca_8bit.sv | 51 +++++
 tb/tb_rca_8bit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder with a combinational sum/carry path and a registered copy of
// sum, carry-out and two's-complement overflow for pipelined consumers.
module rca_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic [7:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q
);

  logic [8:0] carry;
  logic [7:0] sum_d;
  logic       cout_d;
  logic       ovf_d;

  // Explicit full-adder chain; carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[8];
  end

  always_comb begin
    sum_d  = sum;
    cout_d = cout;
    ovf_d  = carry[7] ^ carry[8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= 8'h00;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rca_8bit.sv
// Directed and exhaustive self-checking bench for rca_8bit.
module tb_rca_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic [7:0] sum_q;
  logic       cout_q;
  logic       ovf_q;

  int unsigned checks;
  int unsigned errors;

  rca_8bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a   = av;
    b   = bv;
    cin = cv;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp_v;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a      = 8'h00;
    b      = 8'h00;
    cin    = 1'b0;

    // Reset state
    edge_sample();
    check("rst_sum_q", {1'b0, sum_q}, 9'h000);
    check("rst_cout_q", {8'h00, cout_q}, 9'h000);
    check("rst_ovf_q", {8'h00, ovf_q}, 9'h000);
    rst = 1'b0;

    // Walking one on A and on B
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 2; c++) begin
        exp_v = 9'((1 << i) + c);
        apply(8'(1 << i), 8'h00, 1'(c));
        check("walk_a", {cout, sum}, exp_v);
        apply(8'h00, 8'(1 << i), 1'(c));
        check("walk_b", {cout, sum}, exp_v);
      end
    end

    // Full carry ripple
    apply(8'hFF, 8'h00, 1'b1);
    check("ripple_ff_00_1", {cout, sum}, 9'h100);
    apply(8'hFF, 8'hFF, 1'b1);
    check("ripple_ff_ff_1", {cout, sum}, 9'h1FF);
    edge_sample();
    check("ripple_sum_q", {cout_q, sum_q}, 9'h1FF);
    check("ripple_ovf_q", {8'h00, ovf_q}, 9'h000);

    // Signed overflow
    apply(8'h7F, 8'h01, 1'b0);
    check("ovf_pos_comb", {cout, sum}, 9'h080);
    edge_sample();
    check("ovf_pos_reg", {cout_q, sum_q}, 9'h080);
    check("ovf_pos_ovf_q", {8'h00, ovf_q}, 9'h001);
    apply(8'h80, 8'h80, 1'b0);
    check("ovf_neg_comb", {cout, sum}, 9'h100);
    edge_sample();
    check("ovf_neg_reg", {cout_q, sum_q}, 9'h100);
    check("ovf_neg_ovf_q", {8'h00, ovf_q}, 9'h001);

    // Registered path and asynchronous reset
    apply(8'h12, 8'h34, 1'b0);
    check("reg_comb", {cout, sum}, 9'h046);
    edge_sample();
    check("reg_sum_q", {cout_q, sum_q}, 9'h046);
    check("reg_ovf_q", {8'h00, ovf_q}, 9'h000);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sum_q", {cout_q, sum_q}, 9'h000);
    check("arst_ovf_q", {8'h00, ovf_q}, 9'h000);
    check("arst_comb", {cout, sum}, 9'h046);
    edge_sample();
    check("arst_hold", {cout_q, sum_q}, 9'h000);
    #2;
    rst = 1'b0;
    #1;
    check("rel_before_edge", {cout_q, sum_q}, 9'h000);
    edge_sample();
    check("rel_recapture", {cout_q, sum_q}, 9'h046);

    // Exhaustive sweep
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          exp_v = 9'(ai) + 9'(bi) + 9'(ci);
          apply(8'(ai), 8'(bi), 1'(ci));
          check("sweep", {cout, sum}, exp_v);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
